// File: rtl/dlsc_pcie_s6_outbound_read_tlp_pkg.sv
// Shared TLP header encodings and types for the Spartan-6 outbound TLP formatters.
package dlsc_pcie_s6_outbound_read_tlp_pkg;

    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;

    localparam int unsigned LEN_W    = 10;
    localparam int unsigned REQ_ID_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DW0,
        ST_DW1,
        ST_DW2,
        ST_DW3
    } rd_state_t;

    typedef struct packed {
        logic                four_dw;
        logic [LEN_W-1:0]    len;
        logic [REQ_ID_W-1:0] req_id;
        logic [7:0]          tag;
        logic [3:0]          be_last;
        logic [3:0]          be_first;
        logic [31:0]         addr_hi;
        logic [31:0]         addr_lo;
    } rd_hdr_t;

    // MRd first header dword; TC/TD/EP/attr are always zero.
    function automatic logic [31:0] mrd_dw0(input logic four_dw, input logic [LEN_W-1:0] len);
        return {1'b0, (four_dw ? FMT_4DW_NODATA : FMT_3DW_NODATA), TYPE_MEM, 14'd0, len};
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outbound_read_tlp.sv
// Formats outbound memory-read headers as MRd32/MRd64 TLPs, one dword per beat.
module dlsc_pcie_s6_outbound_read_tlp
    import dlsc_pcie_s6_outbound_read_tlp_pkg::*;
#(
    parameter int unsigned ADDR = 32,
    parameter int unsigned TAG  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dma_en,
    input  logic [7:0]      cfg_bus_number,
    input  logic [4:0]      cfg_device_number,
    input  logic [2:0]      cfg_function_number,
    output logic            rd_tlp_h_ready,
    input  logic            rd_tlp_h_valid,
    input  logic [ADDR-3:0] rd_tlp_h_addr,
    input  logic [9:0]      rd_tlp_h_len,
    input  logic [TAG-1:0]  rd_tlp_h_tag,
    input  logic [3:0]      rd_tlp_h_be_first,
    input  logic [3:0]      rd_tlp_h_be_last,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [31:0]     tx_data,
    output logic            tx_last,
    output logic            tx_sent
);

    rd_state_t   state_q;
    rd_state_t   state_d;
    rd_hdr_t     hdr_q;
    rd_hdr_t     hdr_in;
    logic [31:0] in_addr_hi;
    logic        accept;

    // Upper address dword only exists for wide address configurations.
    generate
        if (ADDR > 32) begin : g_addr_wide
            assign in_addr_hi = 32'(rd_tlp_h_addr[ADDR-3:30]);
        end else begin : g_addr_narrow
            assign in_addr_hi = '0;
        end
    endgenerate

    always_comb begin
        hdr_in          = '0;
        hdr_in.four_dw  = |in_addr_hi;
        hdr_in.len      = rd_tlp_h_len;
        hdr_in.req_id   = {cfg_bus_number, cfg_device_number, cfg_function_number};
        hdr_in.tag      = 8'(rd_tlp_h_tag);
        hdr_in.be_last  = (rd_tlp_h_len == 10'd1) ? 4'b0000 : rd_tlp_h_be_last;
        hdr_in.be_first = rd_tlp_h_be_first;
        hdr_in.addr_hi  = in_addr_hi;
        hdr_in.addr_lo  = {rd_tlp_h_addr[29:0], 2'b00};
    end

    assign tx_valid       = (state_q != ST_IDLE);
    assign tx_last        = ((state_q == ST_DW2) && !hdr_q.four_dw) || (state_q == ST_DW3);
    assign rd_tlp_h_ready = !rst && dma_en && ((state_q == ST_IDLE) || (tx_ready && tx_last));
    assign accept         = rd_tlp_h_ready && rd_tlp_h_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            tx_sent <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_sent <= tx_valid && tx_ready && tx_last;
            if (accept) begin
                hdr_q <= hdr_in;
            end
        end
    end

    // Next state: the last dword hands straight over to a new header when one is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_DW0;
            ST_DW0:  if (tx_ready) state_d = ST_DW1;
            ST_DW1:  if (tx_ready) state_d = ST_DW2;
            ST_DW2: begin
                if (tx_ready) begin
                    if (hdr_q.four_dw) state_d = ST_DW3;
                    else               state_d = accept ? ST_DW0 : ST_IDLE;
                end
            end
            ST_DW3:  if (tx_ready) state_d = accept ? ST_DW0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Dword mux over the captured header registers.
    always_comb begin
        tx_data = '0;
        case (state_q)
            ST_DW0:  tx_data = mrd_dw0(hdr_q.four_dw, hdr_q.len);
            ST_DW1:  tx_data = {hdr_q.req_id, hdr_q.tag, hdr_q.be_last, hdr_q.be_first};
            ST_DW2:  tx_data = hdr_q.four_dw ? hdr_q.addr_hi : hdr_q.addr_lo;
            ST_DW3:  tx_data = hdr_q.addr_lo;
            default: tx_data = '0;
        endcase
    end

endmodule
